// File: rtl/bcd_game_pkg.sv
// bcd_game_pkg: shared definitions for the challenge game.
//   state_t     - game FSM states
//   LFSR_TAPS   - tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   ENCODE      - switch code for each challenge value, indexed by value
//   lfsr_next   - one Fibonacci shift step (shift left, feedback into bit 0)
//   is_target   - true when a nibble is a legal challenge value (1..10)
package bcd_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        WAIT,
        JUDGE,
        DONE
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Entries 0 and 11..15 are never looked up while judging a round.
    localparam logic [4:0] ENCODE [16] = '{
        5'b00000,  // 0 (unused)
        5'b11101,  // 1
        5'b01101,  // 2
        5'b10101,  // 3
        5'b10011,  // 4
        5'b01001,  // 5
        5'b11010,  // 6
        5'b10100,  // 7
        5'b00111,  // 8
        5'b11111,  // 9
        5'b10001,  // 10
        5'b00000,
        5'b00000,
        5'b00000,
        5'b00000,
        5'b00000
    };

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic is_target(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd10);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, loads SEED
//   enable - advance one step per cycle when high
//   state  - current LFSR register contents
module lfsr8
    import bcd_game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [7:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (enable) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/challenge_gen.sv
// challenge_gen: BCD reaction game. Each round picks a pseudo-random value
// 1..10 and waits for the player to submit its 5-bit switch code, or times out.
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - one-cycle pulse, begins a game from IDLE or DONE
//   submit  - one-cycle pulse, commits sw while waiting for an answer
//   sw      - player switch pattern, sampled on submit
//   target  - current challenge value, 0 when no round is active
//   hit     - one-cycle pulse, correct answer
//   miss    - one-cycle pulse, wrong answer or timeout
//   timeout - one-cycle pulse alongside miss when the round timed out
//   score   - correct answers this game
//   round   - rounds completed this game
//   busy    - a game is in progress (PICK, WAIT, JUDGE)
//   done    - game over, final score held
module challenge_gen
    import bcd_game_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS  = 10,
    parameter int unsigned TIMEOUT_CYC = 100_000_000,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       submit,
    input  logic [4:0] sw,
    output logic [3:0] target,
    output logic       hit,
    output logic       miss,
    output logic       timeout,
    output logic [3:0] score,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);

    localparam int unsigned    TCW      = $clog2(TIMEOUT_CYC);
    localparam logic [TCW-1:0] TC_LAST  = TCW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     ROUNDS_N = 4'(NUM_ROUNDS);

    state_t         state;
    logic [TCW-1:0] tcnt;
    logic [4:0]     answer;
    logic [7:0]     lfsr_state;
    logic           lfsr_unused;

    logic           expire;
    logic           finish_round;
    logic [3:0]     round_next;
    logic           last_round;

    lfsr8 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(1'b1),
        .state (lfsr_state)
    );

    // Only the low nibble feeds the challenge; the upper bits just keep the
    // sequence long.
    assign lfsr_unused = ^lfsr_state[7:4];

    // A submit on the expiry cycle takes priority, so expiry needs !submit.
    always_comb begin
        expire       = (state == WAIT) && !submit && (tcnt == TC_LAST);
        finish_round = expire || (state == JUDGE);
        round_next   = round + 4'd1;
        last_round   = (round_next == ROUNDS_N);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            target  <= '0;
            score   <= '0;
            round   <= '0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tcnt    <= '0;
            answer  <= '0;
        end else begin
            hit     <= 1'b0;
            miss    <= 1'b0;
            timeout <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= PICK;
                        score <= '0;
                        round <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                PICK: begin
                    // Reject nibbles outside 1..10 and retry next cycle.
                    if (is_target(lfsr_state[3:0])) begin
                        target <= lfsr_state[3:0];
                        tcnt   <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (submit) begin
                        answer <= sw;
                        state  <= JUDGE;
                    end else if (expire) begin
                        miss    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
                end
                JUDGE: begin
                    if (answer == ENCODE[target]) begin
                        hit   <= 1'b1;
                        score <= score + 4'd1;
                    end else begin
                        miss <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Shared round-end step for both judged and timed-out rounds.
            if (finish_round) begin
                round  <= round_next;
                target <= '0;
                if (last_round) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= PICK;
                end
            end
        end
    end

endmodule

// File: doc/challenge_gen.md
CHALLENGE_GEN -- requirements
Module: challenge_gen

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning rounds per game (1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100_000_000, meaning WAIT-state cycles before a round is forfeited (>=2).
REQ-003 SHALL have parameter SEED, default 8'hA5, meaning nonzero LFSR reset value.
REQ-004 CLK  input  1  sole clock; all state on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 START  input  1  single-cycle pulse, already debounced and synchronous to CLK; begins a game.
REQ-007 SUBMIT  input  1  single-cycle pulse, already debounced and synchronous to CLK; player commits switch pattern.
REQ-008 SW  input  5  player switch pattern {SW4..SW0}, sampled only on SUBMIT.
REQ-009 TARGET  output  4  current challenge value 1..10; 0 when no round is active.
REQ-010 HIT  output  1  one-cycle pulse: correct answer.
REQ-011 MISS  output  1  one-cycle pulse: wrong answer or timeout.
REQ-012 TIMEOUT  output  1  one-cycle pulse coincident with MISS when the cause is timeout.
REQ-013 SCORE  output  4  correct answers this game.
REQ-014 ROUND  output  4  rounds completed this game.
REQ-015 BUSY  output  1  high in PICK, WAIT, JUDGE.
REQ-016 DONE  output  1  high in state DONE.

Function
REQ-017 SHALL implement states IDLE, PICK, WAIT, JUDGE, DONE.
REQ-018 SHALL run an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting every cycle in every state.
REQ-019 IDLE/DONE + START -> PICK; SCORE and ROUND clear to 0 on the same edge.
REQ-020 PICK: if LFSR[3:0] is 1..10, latch it into TARGET and go to WAIT with the timeout counter cleared; otherwise stay in PICK.
REQ-021 WAIT + SUBMIT -> JUDGE; latch SW into an answer register on the same edge.
REQ-022 WAIT with no SUBMIT: increment the timeout counter; when the counter equals TIMEOUT_CYC-1, assert MISS and TIMEOUT for one cycle and go to the round-end step.
REQ-023 SUBMIT in the same cycle as timeout expiry: SUBMIT wins; no TIMEOUT pulse.
REQ-024 JUDGE, one cycle: compare the answer register with ENCODE(TARGET); assert HIT and SCORE+1 on equality, otherwise assert MISS.
REQ-025 Round end: ROUND+1; if the new ROUND equals NUM_ROUNDS -> DONE, else -> PICK; TARGET returns to 0 on entering DONE.
REQ-026 ENCODE table: 1=11101, 2=01101, 3=10101, 4=10011, 5=01001, 6=11010, 7=10100, 8=00111, 9=11111, 10=10001; all codes distinct.
REQ-027 START outside IDLE/DONE and SUBMIT outside WAIT SHALL be ignored.
REQ-028 HIT and MISS SHALL never be high together; exactly one of them fires per round.
REQ-029 SCORE <= ROUND <= NUM_ROUNDS at all times; no wrap.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 RST_N low: state=IDLE, LFSR=SEED, TARGET=0, SCORE=0, ROUND=0, HIT=MISS=TIMEOUT=0, BUSY=0, DONE=0, timeout counter=0.
REQ-032 Reset asserted mid-game SHALL abandon the round immediately, with no pulse emitted.

Structure
REQ-033 Package bcd_game_pkg SHALL hold the state enum, the ENCODE table as a constant array indexed by value, and the LFSR tap constant.
REQ-034 Sub-module lfsr8 (enable, seed parameter, 8-bit state out) SHALL be instantiated once; the rest stays flat.

Verification
REQ-035 Reset, then START -> BUSY=1 within 1 cycle; TARGET in 1..10 by the time the FSM reaches WAIT.
REQ-036 In WAIT, drive SW=ENCODE(TARGET), then SUBMIT -> HIT one cycle after JUDGE entry, SCORE=1, ROUND=1.
REQ-037 TIMEOUT_CYC=16, no SUBMIT -> MISS and TIMEOUT on the 16th WAIT cycle, SCORE=0, ROUND=1.
REQ-038 SUBMIT on the expiry cycle with a wrong SW -> MISS, TIMEOUT=0.
REQ-039 NUM_ROUNDS=3 with all answers correct -> DONE=1, SCORE=3, TARGET=0; a further START clears SCORE and ROUND to 0.
REQ-040 RST_N pulsed low in WAIT -> all outputs at reset values asynchronously; no HIT or MISS emitted.
